// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: default widths, read latency,
// the writable DRAM window and the FSM state encoding.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_WIDTH      = 32;
  localparam int DEF_RD_LAT     = 1;
  localparam int DRAM_BASE      = 4096;
  localparam int DRAM_SIZE      = 4096;

  typedef enum logic {
    IDLE,
    RD_WAIT
  } arbState_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core requesters, the arbiter and the memory.
// The slave modport is the arbiter's view; master is the core/memory side.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WIDTH      = DEF_WIDTH
);

  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  if_gnt_o;
  logic                  if_rvalid_o;
  logic [WIDTH-1:0]      if_rdata_o;

  logic                  d_req_i;
  logic                  d_we_i;
  logic [ADDR_WIDTH-1:0] d_addr_i;
  logic [WIDTH-1:0]      d_wdata_i;
  logic                  d_gnt_o;
  logic                  d_rvalid_o;
  logic [WIDTH-1:0]      d_rdata_o;
  logic                  d_err_o;

  logic                  mem_read_o;
  logic                  mem_write_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [WIDTH-1:0]      mem_wdata_o;
  logic [WIDTH-1:0]      mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
    output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
    input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Two-request priority picker returning a one-hot grant (bit0 = data,
// bit1 = fetch). With MEM_ARB_RR_EN defined the pointer breaks ties
// (0 favours data, 1 favours fetch); otherwise data always wins.
module mem_arb_pick (
`ifdef MEM_ARB_RR_EN
  input  logic       i_ptr,
`endif
  input  logic       i_reqD,
  input  logic       i_reqF,
  output logic [1:0] o_gnt
);

  // Choose a single winner among the active requests
  always_comb begin
    o_gnt = 2'b00;
`ifdef MEM_ARB_RR_EN
    if (i_reqD && i_reqF) begin
      o_gnt = i_ptr ? 2'b10 : 2'b01;
    end else if (i_reqD) begin
      o_gnt = 2'b01;
    end else if (i_reqF) begin
      o_gnt = 2'b10;
    end
`else
    if (i_reqD) begin
      o_gnt = 2'b01;
    end else if (i_reqF) begin
      o_gnt = 2'b10;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch and
// the data port, sequencing reads through RD_LAT cycles and screening data
// writes against the DRAM window. Define MEM_ARB_RR_EN for round-robin
// arbitration; by default data has fixed priority over fetch.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int DRAM_BASE  = mem_arbiter_pkg::DRAM_BASE,
  parameter int DRAM_SIZE  = mem_arbiter_pkg::DRAM_SIZE
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_WIDTH:0] WIN_LO = (ADDR_WIDTH+1)'(DRAM_BASE);
  localparam logic [ADDR_WIDTH:0] WIN_HI = (ADDR_WIDTH+1)'(DRAM_BASE + DRAM_SIZE);

  arbState_e       r_state, w_nextState;
  logic [CW-1:0]   r_cnt, w_nextCnt;
  logic            r_owner, w_nextOwner;
  logic            r_err, w_nextErr;
  logic            w_done, w_canGrant, w_inWin;
  logic [1:0]      w_gnt;

  // Final wait cycle doubles as an idle cycle; nothing is granted in reset
  assign w_done     = (r_state == RD_WAIT) && (r_cnt == '0);
  assign w_canGrant = rst && ((r_state == IDLE) || w_done);
  assign w_inWin    = ({1'b0, bus.d_addr_i} >= WIN_LO) && ({1'b0, bus.d_addr_i} < WIN_HI);

`ifdef MEM_ARB_RR_EN
  logic r_ptr, w_nextPtr;

  assign w_nextPtr = w_gnt[0] ? 1'b1 : (w_gnt[1] ? 1'b0 : r_ptr);

  // Pointer points away from whichever port was granted last
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= 1'b0;
    end else begin
      r_ptr <= w_nextPtr;
    end
  end
`endif

  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .i_ptr  (r_ptr),
`endif
    .i_reqD (bus.d_req_i && w_canGrant),
    .i_reqF (bus.if_req_i && w_canGrant),
    .o_gnt  (w_gnt)
  );

  // Next-state, read response steering and memory drive for the issue cycle
  always_comb begin
    w_nextState     = r_state;
    w_nextCnt       = r_cnt;
    w_nextOwner     = r_owner;
    w_nextErr       = 1'b0;
    bus.if_gnt_o    = 1'b0;
    bus.if_rvalid_o = 1'b0;
    bus.if_rdata_o  = '0;
    bus.d_gnt_o     = 1'b0;
    bus.d_rvalid_o  = 1'b0;
    bus.d_rdata_o   = '0;
    bus.mem_read_o  = 1'b0;
    bus.mem_write_o = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;

    if ((r_state == RD_WAIT) && (r_cnt != '0)) begin
      w_nextCnt = r_cnt - 1'b1;
    end

    if (w_done) begin
      w_nextState = IDLE;
      if (r_owner) begin
        bus.if_rvalid_o = 1'b1;
        bus.if_rdata_o  = bus.mem_rdata_i;
      end else begin
        bus.d_rvalid_o = 1'b1;
        bus.d_rdata_o  = bus.mem_rdata_i;
      end
    end

    if (w_gnt[0]) begin
      bus.d_gnt_o     = 1'b1;
      bus.mem_addr_o  = bus.d_addr_i;
      bus.mem_wdata_o = bus.d_wdata_i;
      if (bus.d_we_i) begin
        bus.mem_write_o = w_inWin;
        w_nextErr       = !w_inWin;
      end else begin
        bus.mem_read_o = 1'b1;
        w_nextState    = RD_WAIT;
        w_nextCnt      = CW'(RD_LAT - 1);
        w_nextOwner    = 1'b0;
      end
    end else if (w_gnt[1]) begin
      bus.if_gnt_o   = 1'b1;
      bus.mem_read_o = 1'b1;
      bus.mem_addr_o = bus.if_addr_i;
      w_nextState    = RD_WAIT;
      w_nextCnt      = CW'(RD_LAT - 1);
      w_nextOwner    = 1'b1;
    end
  end

  assign bus.d_err_o = r_err;

  // State, latency counter, read owner and write-error flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_owner <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_owner <= w_nextOwner;
      r_err   <= w_nextErr;
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter placed between the core and the unified `MEMORY` block. It shares the single memory port between the instruction-fetch requester (read-only) and the data requester (read/write). It sequences each access through the memory's synchronous read latency and steers the read data back to the winning requester. It also screens data writes against the DRAM window, so that an out-of-window store is acknowledged and flagged rather than silently lost.

## Interface
- `ADDR_WIDTH`, 32, address width of the requesters and the memory.
- `WIDTH`, 32, data width.
- `RD_LAT`, 1, memory read latency in cycles (≥1).
- `DRAM_BASE`, 4096, first writable address.
- `DRAM_SIZE`, 4096, size of the writable window in bytes.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `if_req_i` in 1, `if_addr_i` in ADDR_WIDTH: fetch request and address.
- `if_gnt_o` out 1, `if_rvalid_o` out 1, `if_rdata_o` out WIDTH: fetch grant, response strobe and response data.
- `d_req_i` in 1, `d_we_i` in 1, `d_addr_i` in ADDR_WIDTH, `d_wdata_i` in WIDTH: data request.
- `d_gnt_o` out 1, `d_rvalid_o` out 1, `d_rdata_o` out WIDTH, `d_err_o` out 1: data grant, read response and write-range error.
- `mem_read_o` out 1, `mem_write_o` out 1, `mem_addr_o` out ADDR_WIDTH, `mem_wdata_o` out WIDTH: drive the memory.
- `mem_rdata_i` in WIDTH: memory read data.

## Operation
- **Request handshake**
  - A requester holds its `req` and payload stable until it sees `gnt`.
  - A `gnt` is a one-cycle pulse in the issue cycle.
  - Only one `gnt` is asserted per cycle.
- **FSM states**
  - `IDLE`: may grant. A granted read moves to `RD_WAIT` and loads `cnt = RD_LAT-1`. A granted write stays in `IDLE`.
  - `RD_WAIT`: no new grant, except in the final cycle (see below). `cnt` decrements each cycle.
  - When `cnt==0`, the FSM pulses `rvalid` to the owner (registered owner bit) with `mem_rdata_i`. In that same cycle it behaves as `IDLE` and may grant the next access.
- **Memory drive (issue cycle)**
  - `mem_addr_o` and `mem_wdata_o` come from the winner.
  - `mem_read_o` is 1 for reads.
  - `mem_write_o` equals `d_we_i` only when `DRAM_BASE ≤ d_addr_i < DRAM_BASE+DRAM_SIZE`. The compare is unsigned at full ADDR_WIDTH.
  - In all other cycles `mem_read_o`, `mem_write_o`, `mem_addr_o` and `mem_wdata_o` are 0.
- **Writes**
  - A write needs no response: `gnt` completes it.
  - An out-of-window write is still granted, but `mem_write_o` stays 0. `d_err_o` pulses for one cycle, registered, in the cycle after the grant.
- **Arbitration (default)**: fixed priority. The data port wins over fetch when both request.
- **Idle drive**: `if_rdata_o` and `d_rdata_o` are 0 when their `rvalid` is low.

## Timing
- **Reset values**
  - While `rst`=0, every output is 0, the state is `IDLE`, `cnt` is 0 and the owner is data.
  - Reset asserted during `RD_WAIT` drops the outstanding read; no `rvalid` is issued after release.
- **Latency**
  - A read granted at cycle T returns `rvalid` at T+RD_LAT.
  - With RD_LAT=1, throughput is one access per cycle.
- **Simultaneous events**
  - A response completion and a new grant may occur in the same cycle.
  - A write granted in the same cycle as a read completion is legal.
- **Requests in `RD_WAIT`**: a request arriving during `RD_WAIT` waits. Its `gnt` appears at the earliest in the completion cycle.

## Configuration
- **`MEM_ARB_RR_EN` defined**: round-robin arbitration.
  - A 1-bit priority pointer toggles to the other port after each grant.
  - On simultaneous requests the port not most recently granted wins.
  - The pointer resets to favour data.
- **Undefined**: fixed data-over-fetch priority; no pointer register.

## Structure
- **Shared package**: `ADDR_WIDTH`/`WIDTH` defaults, the DRAM window constants (`DRAM_BASE`=4096, `DRAM_SIZE`=4096) and the FSM state enum (`IDLE`, `RD_WAIT`).
- **Sub-module**: `mem_arb_pick`, a pure two-request priority picker. It takes the requests and the pointer and returns a one-hot grant. The `MEM_ARB_RR_EN` logic lives inside it.

## Test plan
1. **Fetch only**: fetch-only read, `if_addr_i`=0x10, memory returns 0xDEADBEEF → `if_gnt_o` at T, `if_rvalid_o`=1 with 0xDEADBEEF at T+1, and `mem_read_o`=1 only at T.
2. **Both request, default build**: both request at T, data reads 0x1000 → `d_gnt_o` at T, `if_gnt_o` at T+1, data `rvalid` at T+1, fetch `rvalid` at T+2.
3. **Both request, round-robin**: with `MEM_ARB_RR_EN`, hold both requests for 4 cycles → grants alternate D, F, D, F.
4. **Write window**: write to 0x1004 with data 0x55 → `mem_write_o`=1 with those values. Write to 0x0800 → `d_gnt_o`=1, `mem_write_o`=0, `d_err_o`=1 at T+1. Write to 0x2000 → error.
5. **Read latency**: with RD_LAT=3, a read at T gives `rvalid` at T+3. A fetch request at T+1 is granted at T+3.
6. **Reset mid-read**: assert `rst`=0 at T+1 of an RD_LAT=3 read → all outputs 0 immediately, and no `rvalid` after release.
